// File: rtl/param_register_file.sv
// Purpose: parametrised 2-read/1-write register file with init sweep, optional zero register and write bypass.
// Latency: reads are combinational (0 cycles); writes land on the rising edge; sweep takes DEPTH edges after reset.
// Backpressure: none; writes presented while init_busy is high (including the sweep-completing edge) are dropped.
module param_register_file #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 5,
  parameter int                 ZERO_REG   = 1,
  parameter int                 BYPASS     = 1,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              init_busy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_busy_q, init_busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Array write port, shared between the init sweep and the normal write path.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Write to entry 0 is swallowed when it is hardwired to zero.
  logic              user_write_ok;
  assign user_write_ok = reg_write && !((ZERO_REG != 0) && (write_addr == '0));

  // Next-state, sweep counter and array write selection.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_busy_d = init_busy_q;
    mem_we      = 1'b0;
    mem_waddr   = write_addr;
    mem_wdata   = write_data;
    if (reset) begin
      state_d     = INIT;
      init_cnt_d  = '0;
      init_busy_d = 1'b1;
    end else if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt_q;
      mem_wdata = INIT_VALUE;
      if (init_cnt_q == LAST_IDX) begin
        state_d     = READY;
        init_busy_d = 1'b0;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end else begin
      mem_we = user_write_ok;
    end
  end

  // Control state registers with synchronous reset (reset values come from the comb block).
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    init_cnt_q  <= init_cnt_d;
    init_busy_q <= init_busy_d;
  end

  // Storage array; contents are defined only by the sweep and accepted writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Per-port read mux: sweep blanking, zero register, bypass, then array.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if (state_q == INIT) begin
      val = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && reg_write && (write_addr == addr)) begin
      val = write_data;
    end else begin
      val = mem_q[addr];
    end
    return val;
  endfunction

  // Both read ports use identical combinational logic.
  always_comb begin
    read_data_1 = read_port(read_addr_1);
    read_data_2 = read_port(read_addr_2);
  end

  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: three instances share clock and reset.
// a: defaults (INIT 0, zero reg, bypass). b: INIT A5A5A5A5, no zero reg, no bypass.
// c: 16-bit x 8 entries, INIT 1234, zero reg, bypass.
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        reset;
  // shared stimulus for instances a and b
  logic        rw;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_busy, b_busy;
  // instance c stimulus
  logic        c_rw;
  logic [2:0]  c_wa, c_ra1, c_ra2;
  logic [15:0] c_wd, c_rd1, c_rd2;
  logic        c_busy;

  int total  = 0;
  int passed = 0;
  int a_fall, c_fall;

  always #5 clk = ~clk;

  param_register_file u_a (
    .clk(clk), .reset(reset), .reg_write(rw), .write_addr(wa), .write_data(wd),
    .read_addr_1(ra1), .read_addr_2(ra2), .read_data_1(a_rd1), .read_data_2(a_rd2),
    .init_busy(a_busy)
  );

  param_register_file #(.ZERO_REG(0), .BYPASS(0), .INIT_VALUE(32'hA5A5A5A5)) u_b (
    .clk(clk), .reset(reset), .reg_write(rw), .write_addr(wa), .write_data(wd),
    .read_addr_1(ra1), .read_addr_2(ra2), .read_data_1(b_rd1), .read_data_2(b_rd2),
    .init_busy(b_busy)
  );

  param_register_file #(.DATA_W(16), .ADDR_W(3), .INIT_VALUE(16'h1234)) u_c (
    .clk(clk), .reset(reset), .reg_write(c_rw), .write_addr(c_wa), .write_data(c_wd),
    .read_addr_1(c_ra1), .read_addr_2(c_ra2), .read_data_1(c_rd1), .read_data_2(c_rd2),
    .init_busy(c_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rw = 1'b0; wa = '0; wd = '0; ra1 = 5'd3; ra2 = 5'd0;
    c_rw = 1'b0; c_wa = '0; c_wd = '0; c_ra1 = 3'd2; c_ra2 = 3'd7;

    // Reset edge: busy high, reads blanked.
    @(posedge clk); #1;
    check("a_busy_reset", {31'd0, a_busy}, 32'd1);
    check("b_busy_reset", {31'd0, b_busy}, 32'd1);
    check("c_busy_reset", {31'd0, c_busy}, 32'd1);
    check("b_rd1_reset", b_rd1, 32'd0);
    check("c_rd1_reset", {16'd0, c_rd1}, 32'd0);
    reset = 1'b0;

    // Sweep length: a/b 32 edges, c 8 edges.
    a_fall = 0; c_fall = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (a_fall == 0 && !a_busy) a_fall = i;
      if (c_fall == 0 && !c_busy) c_fall = i;
      if (i == 5) begin
        check("b_rd1_sweep", b_rd1, 32'd0);
        check("b_rd2_sweep", b_rd2, 32'd0);
      end
    end
    check("a_sweep_len", a_fall, 32'd32);
    check("c_sweep_len", c_fall, 32'd8);
    check("b_busy_done", {31'd0, b_busy}, 32'd0);

    // Post-sweep contents.
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); #1;
      check($sformatf("a_init[%0d]", i), a_rd1, 32'd0);
      check($sformatf("b_init[%0d]", i), b_rd1, 32'hA5A5A5A5);
    end

    // Write addr 9 = 2, read 9 and 10.
    rw = 1'b1; wa = 5'd9; wd = 32'd2; ra1 = 5'd9; ra2 = 5'd10; #1;
    check("a_wr9_bypass", a_rd1, 32'd2);
    check("b_wr9_nobypass", b_rd1, 32'hA5A5A5A5);
    @(posedge clk); #1; rw = 1'b0; #1;
    check("a_rd9", a_rd1, 32'd2);
    check("a_rd10", a_rd2, 32'd0);
    check("b_rd9", b_rd1, 32'd2);
    check("b_rd10", b_rd2, 32'hA5A5A5A5);

    // Write to entry 0.
    rw = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0; #1;
    check("a_zero_wrcycle", a_rd1, 32'd0);
    check("b_zero_wrcycle", b_rd1, 32'hA5A5A5A5);
    @(posedge clk); #1; rw = 1'b0; #1;
    check("a_zero_after", a_rd1, 32'd0);
    check("b_zero_after", b_rd1, 32'hFFFFFFFF);

    // Dual-port bypass on addr 17.
    rw = 1'b1; wa = 5'd17; wd = 32'd99; ra1 = 5'd17; ra2 = 5'd17; #1;
    check("a_byp_p1", a_rd1, 32'd99);
    check("a_byp_p2", a_rd2, 32'd99);
    check("b_nobyp_p1", b_rd1, 32'hA5A5A5A5);
    check("b_nobyp_p2", b_rd2, 32'hA5A5A5A5);
    @(posedge clk); #1; rw = 1'b0; #1;
    check("a_17_next", a_rd1, 32'd99);
    check("b_17_next_p1", b_rd1, 32'd99);
    check("b_17_next_p2", b_rd2, 32'd99);

    // Narrow instance: write top address 7.
    c_rw = 1'b1; c_wa = 3'd7; c_wd = 16'hBEEF; c_ra1 = 3'd7; c_ra2 = 3'd6; #1;
    check("c_byp7", {16'd0, c_rd1}, 32'h0000BEEF);
    @(posedge clk); #1; c_rw = 1'b0; #1;
    check("c_rd7", {16'd0, c_rd1}, 32'h0000BEEF);
    check("c_rd6", {16'd0, c_rd2}, 32'h00001234);
    c_ra1 = 3'd0; c_ra2 = 3'd1; #1;
    check("c_rd0", {16'd0, c_rd1}, 32'd0);
    check("c_rd1", {16'd0, c_rd2}, 32'h00001234);

    // Reset, run 10 sweep edges, reset again.
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("a_busy_mid", {31'd0, a_busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("a_busy_rereset", {31'd0, a_busy}, 32'd1);

    // Fresh sweep with a write to addr 5 held on every sweep edge, including the last.
    a_fall = 0;
    for (int i = 1; i <= 40; i++) begin
      rw = a_busy; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd1; #1;
      if (a_busy) begin
        check($sformatf("a_rd1_sw%0d", i), a_rd1, 32'd0);
        check($sformatf("b_rd1_sw%0d", i), b_rd1, 32'd0);
        check($sformatf("b_rd2_sw%0d", i), b_rd2, 32'd0);
      end
      @(posedge clk); #1;
      if (a_fall == 0 && !a_busy) a_fall = i;
    end
    rw = 1'b0; #1;
    check("a_resweep_len", a_fall, 32'd32);
    check("a_rd5_dropped", a_rd1, 32'd0);
    check("b_rd5_dropped", b_rd1, 32'hA5A5A5A5);
    ra1 = 5'd9; ra2 = 5'd17; #1;
    check("b_rd9_reinit", b_rd1, 32'hA5A5A5A5);
    check("b_rd17_reinit", b_rd2, 32'hA5A5A5A5);
    check("a_rd17_reinit", a_rd2, 32'd0);
    c_ra1 = 3'd7; #1;
    check("c_rd7_reinit", {16'd0, c_rd1}, 32'h00001234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised multi-port register file for the multi-cycle MIPS datapath: two combinational read ports, one clocked write port, a configurable hardwired zero register, and optional same-cycle write-to-read bypass. After reset, an internal sweep state machine writes a known value into every entry. It holds `init_busy` high until the array is consistent. The block sits between instruction decode (read addresses) and the write-back mux (write port), and is a drop-in for the fixed 32x32 file.

## Interface

Parameters:
- `DATA_W`, 32, width of each register in bits.
- `ADDR_W`, 5, address width; depth is `DEPTH = 2**ADDR_W` (derived, not overridable).
- `ZERO_REG`, 1, when 1 entry 0 always reads 0 and ignores writes; when 0 entry 0 is an ordinary register.
- `BYPASS`, 1, when 1 a write in flight is forwarded to a matching read port in the same cycle.
- `INIT_VALUE`, 0, `DATA_W`-bit value written to every entry by the init sweep.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset; restarts the init sweep.
- `reg_write`  in  1  write enable, sampled on rising edge.
- `write_addr`  in  ADDR_W  write address.
- `write_data`  in  DATA_W  write data.
- `read_addr_1`  in  ADDR_W  read port 1 address.
- `read_addr_2`  in  ADDR_W  read port 2 address.
- `read_data_1`  out  DATA_W  read port 1 data (combinational).
- `read_data_2`  out  DATA_W  read port 2 data (combinational).
- `init_busy`  out  1  registered; 1 while the init sweep is running.

## Operation

- State machine has two states: `INIT` and `READY`, with a sweep counter `init_cnt` of width ADDR_W.
- Edge with `reset`=1: state←INIT, `init_cnt`←0, `init_busy`←1. No array write occurs on this edge.
- Edge in INIT with `reset`=0:
  - Writes `INIT_VALUE` to entry `init_cnt`.
  - If `init_cnt`==DEPTH-1: state←READY and `init_busy`←0.
  - Otherwise `init_cnt`←`init_cnt`+1.
  - The counter never wraps.
- Edge in READY with `reset`=0 and `reg_write`=1: entry `write_addr`←`write_data`. The write is suppressed when `ZERO_REG`=1 and `write_addr`=0.
- `reg_write` is ignored in INIT, and on any edge where `reset`=1.
- Read port k (identical logic per port), priority order:
  1. state=INIT: output 0.
  2. `ZERO_REG`=1 and `read_addr_k`=0: output 0.
  3. `BYPASS`=1, state=READY, `reg_write`=1, `write_addr`=`read_addr_k`: output `write_data`.
  4. Otherwise: output array entry `read_addr_k`.
- Both read ports may address the same entry, and both may bypass at once.
- No simulation-only initial contents and no `$display` in synthesizable RTL; contents are defined solely by the sweep.

## Timing

- Reset value of every output:
  - `init_busy`=1 after the first reset edge.
  - `read_data_1` and `read_data_2` = 0 while `init_busy`=1.
  - Before the first reset edge all state is undefined.
- Init latency: exactly DEPTH rising edges with `reset`=0 after the reset edge. `init_busy` falls after the DEPTH-th such edge; for the default parameters this is 32 edges.
- Write handshake: a write is accepted on a rising edge where `init_busy`=1 was NOT the registered value before the edge, i.e. state=READY. A write presented on the edge that completes the sweep is dropped.
- Read latency is 0 cycles (combinational from address).
  - Without bypass, write-then-read of the same entry returns new data starting the cycle after the write edge.
  - With `BYPASS`=1, new data appears in the write cycle itself.
- Reset mid-sweep: the sweep restarts at entry 0, and full DEPTH edges are required again.
- Reset in READY: the array is fully reinitialised to `INIT_VALUE`, and `init_busy` rises on the reset edge.
- Write to `DEPTH-1` with `ADDR_W` at its maximum address: legal, no wrap side effects.

## Test plan

- Reset 1 edge, then deassert. Required: `init_busy`=1 for exactly 32 edges, then 0. After that, reads of addresses 1..31 return `INIT_VALUE`=0 and address 0 returns 0.
- `INIT_VALUE`=32'hA5A5A5A5. Write addr 9 data 32'd2, then read addr 9 on port 1 and addr 10 on port 2. Required: 32'd2 and 32'hA5A5A5A5.
- `ZERO_REG`=1: write addr 0 data 32'hFFFFFFFF. Required: port 1 reads 0, including in the write cycle with `BYPASS`=1. Repeat with `ZERO_REG`=0. Required: 32'hFFFFFFFF after the edge.
- `BYPASS`=1: in one cycle assert `reg_write`, addr 17, data 32'd99, with both read addresses=17. Required: both ports show 32'd99 in the same cycle. Repeat with `BYPASS`=0. Required: old value in that cycle, 32'd99 the next cycle.
- Assert `reset` at sweep count 10, release, then issue `reg_write` to addr 5 during the sweep. Required:
  - `init_busy` stays high for a fresh 32 edges.
  - The write is ignored, so addr 5 reads `INIT_VALUE` after the sweep.
  - Reads return 0 throughout the sweep.
- `DATA_W`=16, `ADDR_W`=3. Required: sweep lasts 8 edges. A write of 16'hBEEF to addr 7 reads back 16'hBEEF, and other entries keep `INIT_VALUE`.
